// File: rtl/sub32_pipe_pkg.sv
// Shared widths and the result flag bundle for the two-stage 32-bit subtractor.
package sub32_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int HALF_W = 16;

  typedef struct packed {
    logic bo;
    logic ovf;
    logic zero;
  } flags_t;
endpackage

// File: rtl/sub32_pipe_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit groups with lookahead across groups.
module cla16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        ci,
  output logic [15:0] s,
  output logic        co
);
  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  always_comb begin
    g  = x & y;
    p  = x ^ y;
    gg = '0;
    gp = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Group carries resolved in parallel from the group generate/propagate terms.
    gc[0] = ci;
    gc[1] = gg[0] | (gp[0] & ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & ci);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & ci);
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    s  = p ^ c;
    co = gc[4];
  end
endmodule

// File: rtl/sub32_pipe.sv
// Two-stage 32-bit subtractor d = a - b - bi with valid/ready flow control;
// the low half resolves in stage 1, the high half and flags in stage 2.
module sub32_pipe
  import sub32_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bi,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] d,
  output logic              bo,
  output logic              ovf,
  output logic              zero,
  output logic              out_valid,
  input  logic              out_ready
);
  logic              vld_p1;
  logic [HALF_W-1:0] lo_p1;
  logic              c_p1;
  logic [HALF_W-1:0] ahi_p1;
  logic [HALF_W-1:0] nbhi_p1;
  logic              a31_p1;
  logic              b31_p1;

  logic              vld_p2;
  logic [DATA_W-1:0] d_p2;
  flags_t            flags_p2;

  logic              ld2;
  logic              ld1;
  logic [HALF_W-1:0] lo_sum;
  logic              lo_co;
  logic [HALF_W-1:0] hi_sum;
  logic              hi_co;
  logic [DATA_W-1:0] d_full;
  flags_t            flags_nxt;

  assign ld2      = ~vld_p2 | out_ready;
  assign in_ready = ~rst & (~vld_p1 | ld2);
  assign ld1      = in_ready;

  cla16 u_lo (
    .x  (a[HALF_W-1:0]),
    .y  (~b[HALF_W-1:0]),
    .ci (~bi),
    .s  (lo_sum),
    .co (lo_co)
  );

  cla16 u_hi (
    .x  (ahi_p1),
    .y  (nbhi_p1),
    .ci (c_p1),
    .s  (hi_sum),
    .co (hi_co)
  );

  always_comb begin
    d_full         = {hi_sum, lo_p1};
    flags_nxt.bo   = ~hi_co;
    flags_nxt.ovf  = (a31_p1 != b31_p1) && (d_full[DATA_W-1] != a31_p1);
    flags_nxt.zero = (d_full == '0);
  end

  // Stage 1: low-half sum and carry, high-half operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (ld1) begin
      vld_p1 <= in_valid;
    end
    if (ld1 && in_valid) begin
      lo_p1   <= lo_sum;
      c_p1    <= lo_co;
      ahi_p1  <= a[DATA_W-1:HALF_W];
      nbhi_p1 <= ~b[DATA_W-1:HALF_W];
      a31_p1  <= a[DATA_W-1];
      b31_p1  <= b[DATA_W-1];
    end
  end

  // Stage 2: high-half sum, flags and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      d_p2     <= '0;
      flags_p2 <= '0;
    end else if (ld2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        d_p2     <= d_full;
        flags_p2 <= flags_nxt;
      end
    end
  end

  assign d         = d_p2;
  assign bo        = flags_p2.bo;
  assign ovf       = flags_p2.ovf;
  assign zero      = flags_p2.zero;
  assign out_valid = vld_p2;
endmodule

// File: tb/tb_sub32_pipe.sv
// Scoreboard bench for sub32_pipe: the driver queues expected results, the monitor checks outputs.
module tb_sub32_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] d;
  logic        bo;
  logic        ovf;
  logic        zero;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ovf;
    logic        zero;
  } exp_t;
  exp_t sb[$];

  sub32_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .bo        (bo),
    .ovf       (ovf),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the operand set is accepted.
  task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tbi,
                      input logic [31:0] ed, input logic ebo, input logic eovf,
                      input logic ezero, input bit push);
    exp_t e;
    bit   done = 0;
    a = ta; b = tb_; bi = tbi; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (in_ready) begin
        if (push) begin
          e.d = ed; e.bo = ebo; e.ovf = eovf; e.zero = ezero;
          sb.push_back(e);
        end
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected accept within 50 cycles");
    end
  endtask

  // Monitor: samples between the negedge drive and the next posedge.
  logic [31:0] prev_d;
  logic [2:0]  prev_f;
  bit          prev_stall = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (prev_stall) begin
          check("stall_valid_held", {31'd0, out_valid}, 32'd1);
          check("stall_d_held", d, prev_d);
          check("stall_flags_held", {29'd0, bo, ovf, zero}, {29'd0, prev_f});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got d=0x%08h expected no result", d);
          end else begin
            e = sb.pop_front();
            check("d", d, e.d);
            check("bo", {31'd0, bo}, {31'd0, e.bo});
            check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
            check("zero", {31'd0, zero}, {31'd0, e.zero});
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d = d;
        prev_f = {bo, ovf, zero};
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    rst = 1'b1; a = '0; b = '0; bi = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_d", d, 32'd0);
    check("rst_flags", {29'd0, bo, ovf, zero}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);

    // Basic and boundary vectors, back to back.
    send(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1);
    send(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1);
    send(32'h1234_0000, 32'h1233_FFFF, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1);
    send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1);
    repeat (4) @(negedge clk);
    check("drain1", sb.size(), 0);

    // Stall: two accepts fill the pipe, the third waits.
    out_ready = 1'b0;
    send(32'h0000_0010, 32'h0000_0001, 1'b1, 32'h0000_000E, 1'b0, 1'b0, 1'b0, 1);
    send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 32'hFFFE_0000, 1'b0, 1'b0, 1'b0, 1);
    a = 32'h0000_0000; b = 32'h0000_0000; bi = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    send(32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1);
    send(32'hAAAA_5555, 32'h5555_AAAA, 1'b0, 32'h5554_AAAB, 1'b0, 1'b1, 1'b0, 1);
    repeat (4) @(negedge clk);
    check("drain2", sb.size(), 0);

    // Reset with two sets in flight: both must vanish.
    out_ready = 1'b0;
    send(32'h0000_0009, 32'h0000_0002, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    send(32'h0000_0007, 32'h0000_0002, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    send(32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("final_queue_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
